// File: rtl/heartbeat_sched.sv
// heartbeat_sched: round-robin owner of one shared N-bit up-counter.
// Grants one requester at a time, counts 0..len, then pulses done.
module heartbeat_sched #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic           clk,
    input  logic           nreset,
    input  logic [M-1:0]   req,
    input  logic [M*N-1:0] len,
    output logic [M-1:0]   grant,
    output logic [M-1:0]   done,
    output logic           busy,
    output logic [N-1:0]   count
);

    localparam int PW = $clog2(M);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [N-1:0]  len_q;
    logic [PW-1:0] ptr;
    logic [PW-1:0] own;
    logic [PW-1:0] own_nxt;
    logic [PW-1:0] win;
    logic          found;

    // Search starts at ptr and wraps, giving strict round-robin order.
    always_comb begin : pick
        int j;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < M; i++) begin
            j = int'(ptr) + i;
            if (j >= M) j = j - M;
            if (!found && req[j]) begin
                found = 1'b1;
                win   = PW'(j);
            end
        end
    end

    assign own_nxt = (own == PW'(M - 1)) ? '0 : own + PW'(1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
            grant <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
            len_q <= '0;
            ptr   <= '0;
            own   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant <= M'(1) << win;
                        own   <= win;
                        len_q <= len[win*N +: N];
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Owner withdrawing wins over a same-cycle match.
                    if (!req[own]) begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        ptr   <= own_nxt;
                    end else if (count == len_q) begin
                        state <= DONE;
                        done  <= grant;
                    end else begin
                        count <= count + N'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    ptr   <= own_nxt;
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_heartbeat_sched.sv
// tb_heartbeat_sched: directed reset/single-job checks plus a randomized
// job-level reference model feeding a done-pulse scoreboard.
module tb_heartbeat_sched;

    localparam int N = 8;
    localparam int M = 4;

    logic           clk = 1'b0;
    logic           nreset = 1'b0;
    logic [M-1:0]   req = '0;
    logic [M*N-1:0] len = '0;
    logic [M-1:0]   grant;
    logic [M-1:0]   done;
    logic           busy;
    logic [N-1:0]   count;

    heartbeat_sched #(.N(N), .M(M)) dut (
        .clk    (clk),
        .nreset (nreset),
        .req    (req),
        .len    (len),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .count  (count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int owner;
        int cyc;
        int cnt;
    } exp_t;

    exp_t sb[$];

    int nvec = 0;
    int nerr = 0;
    bit mon_en = 1'b0;

    logic [M-1:0] one = 1;
    logic [M-1:0] exp_grant = '0;
    bit           exp_busy = 1'b0;
    int           exp_count = 0;

    // Job-level model: who is pending, current job window, rr pointer.
    bit pend[M];
    int plen[M];
    int m_ptr = 0;
    int j_t0 = -100;
    int j_w = 0;
    int j_len = 0;
    int j_idle = 0;
    int j_drop = -1;
    bit arrive_en = 1'b1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d",
                     nm, cyc, act, expv);
        end
    endtask

    function automatic int rand_len();
        int r;
        r = $urandom_range(7);
        if (r == 0) return 0;
        if (r == 1) return 255;
        return $urandom_range(15);
    endfunction

    // One model cycle, called just after the edge that starts cycle c.
    task automatic step();
        int  c;
        int  w;
        int  k;
        int  d;
        bit  f;
        c = cyc;
        exp_busy  = (c > j_t0) && (c < j_idle);
        exp_grant = exp_busy ? (one << j_w) : '0;
        d = c - j_t0 - 1;
        exp_count = exp_busy ? ((d > j_len) ? j_len : d) : 0;
        if (arrive_en) begin
            for (int i = 0; i < M; i++) begin
                if (!pend[i] && $urandom_range(5) == 0) begin
                    pend[i] = 1'b1;
                    plen[i] = rand_len();
                end
            end
        end
        if (c == j_drop) pend[j_w] = 1'b0;
        if (c >= j_idle) begin
            f = 1'b0;
            w = 0;
            for (int i = 0; i < M; i++) begin
                k = (m_ptr + i) % M;
                if (!f && pend[k]) begin
                    f = 1'b1;
                    w = k;
                end
            end
            if (f) begin
                j_t0  = c;
                j_w   = w;
                j_len = plen[w];
                if ($urandom_range(3) == 0) begin
                    k = $urandom_range(j_len);
                    j_drop = c + 1 + k;
                    j_idle = c + 2 + k;
                end else begin
                    j_drop = c + 2 + j_len;
                    j_idle = c + 3 + j_len;
                    sb.push_back('{w, c + 2 + j_len, j_len});
                end
                m_ptr = (w + 1) % M;
            end
        end
        for (int i = 0; i < M; i++) begin
            req[i] = pend[i];
            if (pend[i] && !(i == j_w && c > j_t0 && c < j_idle))
                len[i*N +: N] = N'(plen[i]);
            else
                len[i*N +: N] = N'($urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("grant", 32'(grant), 32'(exp_grant));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_busy) chk("count", 32'(count), 32'(exp_count));
            if (done !== '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_owner", 32'(done), 32'(one << e.owner));
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_count", 32'(count), e.cnt);
                end
            end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                chk("missed_done", cyc, e.cyc);
            end
        end
    end

    initial begin
        int npend;
        for (int i = 0; i < M; i++) begin
            pend[i] = 1'b0;
            plen[i] = 0;
        end

        // Reset holds everything at zero whatever the inputs do.
        nreset = 1'b0;
        req = 4'($urandom);
        len = 32'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(count), 0);
        req = '0;
        nreset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_grant", 32'(grant), 0);

        // Single job: requester 1, length 5.
        @(posedge clk);
        #1;
        req = 4'b0010;
        len = 32'($urandom);
        len[15:8] = 8'd5;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) len[15:8] = 8'd77;
            @(negedge clk);
            if (k <= 6) begin
                chk("sj_grant", 32'(grant), 32'(4'b0010));
                chk("sj_busy", 32'(busy), 1);
                chk("sj_count", 32'(count), k - 1);
                chk("sj_nodone", 32'(done), 0);
            end else if (k == 7) begin
                chk("sj_done", 32'(done), 32'(4'b0010));
                chk("sj_dcount", 32'(count), 5);
                req = '0;
            end else begin
                chk("sj_end_busy", 32'(busy), 0);
                chk("sj_end_grant", 32'(grant), 0);
                chk("sj_end_done", 32'(done), 0);
            end
        end

        // Reset mid-job must clear outputs and the round-robin pointer.
        req = 4'b1000;
        len[31:24] = 8'd40;
        repeat (4) @(posedge clk);
        #2;
        chk("mj_grant", 32'(grant), 32'(4'b1000));
        nreset = 1'b0;
        #1;
        chk("mr_grant", 32'(grant), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_done", 32'(done), 0);
        chk("mr_count", 32'(count), 0);
        req = 4'b0101;
        len[7:0] = 8'd3;
        len[23:16] = 8'd3;
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mr_ptr0", 32'(grant), 32'(4'b0001));
        req = '0;
        repeat (2) @(posedge clk);
        nreset = 1'b0;
        @(negedge clk);
        nreset = 1'b1;

        // Randomized traffic against the job-level model.
        @(posedge clk);
        #1;
        j_idle = cyc;
        step();
        mon_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk);
            #1;
            step();
        end
        arrive_en = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            npend = 0;
            for (int i = 0; i < M; i++) npend += int'(pend[i]);
            if (npend == 0 && cyc > j_idle && sb.size() == 0) break;
            @(posedge clk);
            #1;
            step();
        end
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("drain_sb", sb.size(), 0);
        chk("drain_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/heartbeat_sched.md
# heartbeat_sched

Round-robin scheduler that shares one N-bit up-counter and its incrementer among M requesters. Each requester asks for a timed interval of programmable length. The scheduler grants one requester at a time, runs the shared counter from 0 to the requested length, and signals completion with a one-cycle done pulse. It sits between the client blocks and the shared counter/incrementer datapath, and is the only block that sequences that datapath.

## Interface
- N, 8, counter and length width in bits (N ≥ 1)
- M, 4, number of requesters (M ≥ 2); pointer width is clog2(M)
- clk  input  1  clock, rising edge
- nreset  input  1  reset, asynchronous, active-low
- req  input  M  request per requester, level, held until done
- len  input  M*N  interval length per requester; requester i uses len[i*N +: N]
- grant  output  M  one-hot owner of the counter; all zeros when idle
- done  output  M  one-cycle completion pulse to the owner
- busy  output  1  high when state ≠ IDLE
- count  output  N  current shared counter value

## Operation
- FSM states: IDLE, RUN, DONE. All outputs and state are registered.
- **IDLE**
  - If req ≠ 0: winner w = lowest index ≥ ptr with req[w]=1; if none, wrap and take the lowest index < ptr.
  - On the same edge: grant ← onehot(w), len_q ← len[w], count ← 0, state ← RUN.
  - If req = 0: stay in IDLE.
- **RUN**
  - count ← count + 1, through the shared incrementer, modulo 2^N.
  - If count == len_q: state ← DONE, done ← grant.
  - If req[w] drops during RUN (abort): state ← IDLE, grant ← 0, count ← 0, no done pulse, ptr ← (w+1) mod M. Abort has priority over a match in the same cycle.
- **DONE**
  - done is high for exactly this one cycle.
  - On exit: state ← IDLE, grant ← 0, done ← 0, ptr ← (w+1) mod M.
- len is sampled only in IDLE. Later changes to len have no effect on the running job.
- req of non-owners is ignored outside IDLE. Those requests stay pending.
- Requester contract: drop req on the edge that ends the done cycle. If req is still high in the following IDLE cycle, it is treated as a new request.
- Count range: len_q = 0 gives one RUN cycle. len_q = 2^N−1 gives 2^N RUN cycles. The counter never wraps within a job.

## Timing
- Reset values: state IDLE, grant 0, done 0, busy 0, count 0, len_q 0, ptr 0.
- Reset assertion mid-job clears everything immediately (asynchronously). No done pulse is issued.
- Let t0 be the IDLE cycle in which req is sampled. Then:
  - grant and busy are high from t0+1.
  - RUN occupies cycles t0+1 through t0+1+len_q.
  - done is high in cycle t0+2+len_q.
  - IDLE resumes at t0+3+len_q.
- Request-to-done latency is len_q+2 cycles. Back-to-back jobs are separated by one IDLE cycle.
- count shows 0, 1, …, len_q during RUN and holds len_q during DONE.
- Simultaneous requests: fairness is strict round-robin. Each pending requester is served within M jobs.

## Test plan
- **Reset values:** nreset low, random inputs → all outputs 0. Release, req=0 → stays idle, busy=0.
- **Single job:** req=4'b0010, len1=5 → grant=0010 from t0+1; count 0..5; done=0010 only at t0+7; busy falls at t0+8.
- **Round-robin:** req=4'b1111 held, each requester drops req after its own done → grant order 0001, 0010, 0100, 1000, then 0001 again for a new request. Exactly one IDLE cycle between jobs.
- **Boundary lengths:** len=0 → done at t0+2. len=255 (N=8) → 256 RUN cycles, count reaches 255, no wrap, done at t0+257.
- **Abort:** owner drops req at count=3 → next cycle grant=0, busy=0, no done, ptr advances. A pending requester is granted in the following IDLE cycle.
- **Reset mid-job:** nreset pulsed low during RUN → outputs 0 immediately. After release, ptr=0, so requester 0 wins if req=4'b0101.
